mips_debug_ctrl: RTL and testbench
==================================

Name: mips_debug_ctrl

Overview:
- Sequences the MIPS core from the MicroBlaze GPIO link.
- Decodes command words from the GPIO output port and gates the pipeline enable: run, single/multi-step or stop.
- Arbitrates read access to the core's debug sources (register file, data memory, pipeline latches) and returns results on the GPIO input port with a toggle handshake.
- Sits between the GPIO block and the MIPS top, in the 50 MHz application clock domain.

Parameters:
- NB_BITS, 32, GPIO/data word width.
- NB_ADDR, 10, debug source address width.
- READ_LAT, 2, cycles from o_dbg_req to valid i_dbg_data (1..7).
- NB_SYNC, 2, synchronizer stages on i_gpio.

Ports:
- i_clk  in  1  application clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_gpio  in  NB_BITS  command word: [30] valid strobe, [28:25] opcode, [24:0] argument.
- o_gpio  out  NB_BITS  response data word.
- o_ack  out  1  toggles once per completed command.
- o_busy  out  1  high while a command is in progress (not IDLE).
- o_pipe_en  out  1  MIPS pipeline clock enable.
- i_halt  in  1  core retired HALT; level, sampled every cycle.
- o_dbg_sel  out  4  debug source: 1=regfile, 2=data mem, 4=latches, 0=none.
- o_dbg_addr  out  NB_ADDR  debug source address.
- o_dbg_req  out  1  one-cycle read request.
- i_dbg_data  in  NB_BITS  debug read data.

Behaviour:
- Reset values: o_gpio=0, o_ack=0, o_busy=0, o_pipe_en=0, o_dbg_sel=0, o_dbg_addr=0, o_dbg_req=0. Cycle counter=0, step counter=0, state=IDLE, synchronizer flops=0.
- Reset may assert in any state. It aborts the current command, drops o_pipe_en immediately (asynchronous), and emits no ack.
- Input synchronization: i_gpio passes through NB_SYNC flops. A command is accepted only on a rising edge of synced bit 30, in IDLE. Opcode and argument are captured on the same synced word.
- Rising edges outside IDLE are ignored; no ack is produced for them. The host must wait for the ack toggle before issuing the next command.
- Opcodes:
  - 0 NOP: ack only.
  - 1 RUN: o_pipe_en=1 until i_halt=1 or a STOP command.
  - 2 STEP: enable for N=arg[15:0] cycles; N=0 is treated as 1.
  - 3 STOP: o_pipe_en=0.
  - 4 RDREG: sel=1, addr=arg[4:0].
  - 5 RDMEM: sel=2, addr=arg[NB_ADDR-1:0].
  - 6 RDLATCH: sel=4, addr=arg[NB_ADDR-1:0].
  - 7 STATUS: o_gpio={29'd0, halted, running, busy}.
  - 8 CYCLES: o_gpio=cycle counter.
  - 9..15: ack with o_gpio=32'hFFFF_FFFF (illegal).
- States:
  - IDLE: wait for accepted edge; go to DECODE.
  - DECODE (1 cycle): RUN goes to RUNNING; STEP loads the step counter and goes to STEPPING; reads go to RD_REQ; all others go to RESP.
  - RUNNING: o_pipe_en=1. RUNNING is an ack-then-run state: the RUN ack is issued on entry and o_busy=0 while in RUNNING, so the host can send STOP. Exits to IDLE on i_halt=1 sampled high, with o_pipe_en=0 in the following cycle, or on a STOP edge. STOP in RUNNING goes to RESP, which acks the STOP.
  - STEPPING: o_pipe_en=1 exactly N cycles, then RESP. i_halt during a step ends the step early and goes to RESP.
  - RD_REQ: o_dbg_req=1 for one cycle; o_dbg_sel/o_dbg_addr are held from RD_REQ through RD_WAIT. Then RD_WAIT.
  - RD_WAIT: count READ_LAT cycles, capture i_dbg_data into o_gpio, go to RESP.
  - RESP: toggle o_ack, return sel to 0, go to IDLE.
- o_gpio holds its last value until the next response.
- Latency, edge accepted to ack toggle:
  - NOP/STOP/STATUS/CYCLES: NB_SYNC+3 cycles.
  - Reads: NB_SYNC+4+READ_LAT cycles.
  - STEP: NB_SYNC+3+N cycles.
- Cycle counter: 32-bit, increments each cycle o_pipe_en=1, wraps FFFF_FFFF to 0, cleared only by reset.
- halted flag: set when i_halt is seen with o_pipe_en=1; cleared by the next RUN/STEP.
- A RUN or STEP issued while halted runs normally; the core is responsible for its own HALT state.

Test Plan:
- Reset mid-RUNNING → o_pipe_en=0 same cycle; o_ack=0; CYCLES after release reads 0.
- STEP arg=5 → o_pipe_en high exactly 5 consecutive cycles; o_ack toggles; CYCLES=5. STEP arg=0 → 1 cycle.
- RUN, i_halt asserted after 20 enabled cycles → o_pipe_en low next cycle; STATUS returns 32'h4; CYCLES=20 (±halt sample cycle as specified).
- RDMEM arg=0x3C3 with READ_LAT=2 → o_dbg_req pulses once with sel=2, addr=0x3C3; o_gpio equals i_dbg_data presented 2 cycles later; ack at NB_SYNC+6.
- Valid edge while STEPPING with N=100 → ignored, exactly one ack total. Opcode 12 → o_gpio=FFFF_FFFF with ack.
- Cycle counter preset near wrap (force 32'hFFFF_FFFE) plus STEP 3 → CYCLES=1.

Source files
------------

// File: rtl/mips_debug_ctrl.sv
// mips_debug_ctrl
//   Debug sequencer between the MicroBlaze GPIO link and the MIPS core.
//   Command words arrive on i_gpio through a synchronizer. Each accepted
//   command either gates the pipeline enable (run, step, stop), performs
//   one read from a debug source, or reports status or the cycle count.
//   Completion is signalled by toggling o_ack. The response word is left
//   on o_gpio until the next response replaces it.
//
// Parameters
//   NB_BITS  : GPIO/data word width (command layout assumes 32).
//   NB_ADDR  : debug source address width (at most 16).
//   READ_LAT : cycles from o_dbg_req to valid i_dbg_data (1..7).
//   NB_SYNC  : synchronizer stages on i_gpio.
//
// Ports
//   i_clk, i_rst : application clock, asynchronous active-high reset.
//   i_gpio       : command word: [30] valid strobe, [28:25] opcode, [24:0] arg.
//   o_gpio       : response data word.
//   o_ack        : toggles once per completed command.
//   o_busy       : high while a command is in progress.
//   o_pipe_en    : MIPS pipeline clock enable.
//   i_halt       : core retired HALT (level).
//   o_dbg_sel    : debug source select (1 regfile, 2 data mem, 4 latches).
//   o_dbg_addr   : debug source address.
//   o_dbg_req    : one-cycle read request.
//   i_dbg_data   : debug read data.

module mips_debug_ctrl #(
  parameter int NB_BITS  = 32,
  parameter int NB_ADDR  = 10,
  parameter int READ_LAT = 2,
  parameter int NB_SYNC  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_BITS-1:0] i_gpio,
  output logic [NB_BITS-1:0] o_gpio,
  output logic               o_ack,
  output logic               o_busy,
  output logic               o_pipe_en,
  input  logic               i_halt,
  output logic [3:0]         o_dbg_sel,
  output logic [NB_ADDR-1:0] o_dbg_addr,
  output logic               o_dbg_req,
  input  logic [NB_BITS-1:0] i_dbg_data
);

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_RUN     = 4'd1;
  localparam logic [3:0] OP_STEP    = 4'd2;
  localparam logic [3:0] OP_STOP    = 4'd3;
  localparam logic [3:0] OP_RDREG   = 4'd4;
  localparam logic [3:0] OP_RDMEM   = 4'd5;
  localparam logic [3:0] OP_RDLATCH = 4'd6;
  localparam logic [3:0] OP_STATUS  = 4'd7;
  localparam logic [3:0] OP_CYCLES  = 4'd8;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    RUNNING,
    STEPPING,
    RD_REQ,
    RD_WAIT,
    RESP
  } state_t;

  state_t state, state_next;

  logic [NB_BITS-1:0] sync_q [NB_SYNC];
  logic [NB_BITS-1:0] synced;
  logic               valid_prev;
  logic               rise;
  logic [3:0]         cmd_op;
  logic [15:0]        cmd_arg;
  logic               spare_bits_unused;

  logic [3:0]         op_q;
  logic [15:0]        arg_q;
  logic [15:0]        step_cnt;
  logic [2:0]         lat_cnt;
  logic               lat_done;
  logic [31:0]        cycle_cnt;
  logic               halted;

  // Whole command word travels through the same flop chain, so opcode and
  // argument are coherent with the valid bit that produced the edge.
  assign synced  = sync_q[NB_SYNC-1];
  assign rise    = synced[30] & ~valid_prev;
  assign cmd_op  = synced[28:25];
  assign cmd_arg = synced[15:0];

  // Command bits that no opcode consumes.
  assign spare_bits_unused = ^{synced[NB_BITS-1:31], synced[29], synced[24:16]};

  assign lat_done = (lat_cnt == 3'(READ_LAT - 1));

  // Synchronizer chain and valid-strobe edge history; runs in every state
  // so an edge that arrives outside IDLE is consumed and never replayed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NB_SYNC; i++) sync_q[i] <= '0;
      valid_prev <= 1'b0;
    end else begin
      sync_q[0] <= i_gpio;
      for (int i = 1; i < NB_SYNC; i++) sync_q[i] <= sync_q[i-1];
      valid_prev <= synced[30];
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and the state-decoded outputs. o_pipe_en comes straight
  // from the state register so reset drops it without waiting for a clock.
  always_comb begin
    state_next = state;
    o_pipe_en  = 1'b0;
    o_busy     = 1'b1;
    o_dbg_req  = 1'b0;
    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (rise) state_next = DECODE;
      end
      DECODE: begin
        case (op_q)
          OP_RUN:                         state_next = RUNNING;
          OP_STEP:                        state_next = STEPPING;
          OP_RDREG, OP_RDMEM, OP_RDLATCH: state_next = RD_REQ;
          default:                        state_next = RESP;
        endcase
      end
      RUNNING: begin
        // Run was already acked, so the host sees the controller as free
        // and may send STOP; STOP wins over a simultaneous halt so it still
        // gets its ack.
        o_busy    = 1'b0;
        o_pipe_en = 1'b1;
        if (rise && cmd_op == OP_STOP) state_next = RESP;
        else if (i_halt)               state_next = IDLE;
      end
      STEPPING: begin
        o_pipe_en = 1'b1;
        if (i_halt || step_cnt == 16'd1) state_next = RESP;
      end
      RD_REQ: begin
        o_dbg_req  = 1'b1;
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_done) state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Command capture, counters, debug port registers and the response word.
  // The RUN ack is toggled on the way into RUNNING; every other command is
  // acked from RESP.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_gpio     <= '0;
      o_ack      <= 1'b0;
      o_dbg_sel  <= 4'd0;
      o_dbg_addr <= '0;
      op_q       <= OP_NOP;
      arg_q      <= 16'd0;
      step_cnt   <= 16'd0;
      lat_cnt    <= 3'd0;
      cycle_cnt  <= 32'd0;
      halted     <= 1'b0;
    end else begin
      if (o_pipe_en) cycle_cnt <= cycle_cnt + 32'd1;
      if (o_pipe_en && i_halt) halted <= 1'b1;

      case (state)
        IDLE: begin
          if (rise) begin
            op_q  <= cmd_op;
            arg_q <= cmd_arg;
          end
        end
        DECODE: begin
          lat_cnt <= 3'd0;
          case (op_q)
            OP_NOP, OP_STOP: ;
            OP_RUN: begin
              halted <= 1'b0;
              o_ack  <= ~o_ack;
            end
            OP_STEP: begin
              halted   <= 1'b0;
              step_cnt <= (arg_q == 16'd0) ? 16'd1 : arg_q;
            end
            OP_RDREG: begin
              o_dbg_sel  <= 4'd1;
              o_dbg_addr <= NB_ADDR'(arg_q[4:0]);
            end
            OP_RDMEM: begin
              o_dbg_sel  <= 4'd2;
              o_dbg_addr <= arg_q[NB_ADDR-1:0];
            end
            OP_RDLATCH: begin
              o_dbg_sel  <= 4'd4;
              o_dbg_addr <= arg_q[NB_ADDR-1:0];
            end
            // Only accepted from IDLE, so the core was neither running nor
            // was the controller busy at the moment the request was taken.
            OP_STATUS: o_gpio <= {{(NB_BITS-3){1'b0}}, halted, 2'b00};
            OP_CYCLES: o_gpio <= NB_BITS'(cycle_cnt);
            default:   o_gpio <= '1;
          endcase
        end
        STEPPING: begin
          step_cnt <= step_cnt - 16'd1;
        end
        RD_WAIT: begin
          lat_cnt <= lat_cnt + 3'd1;
          if (lat_done) o_gpio <= i_dbg_data;
        end
        RESP: begin
          o_ack     <= ~o_ack;
          o_dbg_sel <= 4'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// tb_mips_debug_ctrl
//   Scoreboard bench for mips_debug_ctrl. Commands are issued through the
//   GPIO word; a reference model derived from the command rules predicts the
//   response word, ack timing and cycle count, and queues the expectation.
//   A monitor pops and compares each time o_ack toggles. A responder models
//   the debug sources with fixed read latency, returning junk on other cycles.

module tb_mips_debug_ctrl;

  localparam int NB_BITS  = 32;
  localparam int NB_ADDR  = 10;
  localparam int READ_LAT = 2;
  localparam int NB_SYNC  = 2;

  logic               clk;
  logic               rst;
  logic [31:0]        gpio_cmd;
  logic [31:0]        gpio_rsp;
  logic               ack;
  logic               busy;
  logic               pipe_en;
  logic               halt;
  logic [3:0]         dbg_sel;
  logic [NB_ADDR-1:0] dbg_addr;
  logic               dbg_req;
  logic [31:0]        dbg_data;

  mips_debug_ctrl #(
    .NB_BITS(NB_BITS), .NB_ADDR(NB_ADDR), .READ_LAT(READ_LAT), .NB_SYNC(NB_SYNC)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_gpio(gpio_cmd), .o_gpio(gpio_rsp),
    .o_ack(ack), .o_busy(busy), .o_pipe_en(pipe_en), .i_halt(halt),
    .o_dbg_sel(dbg_sel), .o_dbg_addr(dbg_addr), .o_dbg_req(dbg_req),
    .i_dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          exp_cyc;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          pe_count = 0;
  int          ack_count = 0;
  int          req_count = 0;
  logic        prev_ack = 1'b0;

  // Debug source contents and responder bookkeeping.
  logic [31:0]        reg_mem   [1024];
  logic [31:0]        dmem      [1024];
  logic [31:0]        latch_mem [1024];
  logic [3:0]         req_sel;
  logic [NB_ADDR-1:0] req_addr;
  int                 req_age = -1;

  // Reference model state.
  logic [31:0] m_cycles;
  logic [31:0] m_last;
  bit          m_halted;
  int          m_reads;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] src_read(input logic [3:0] sel, input logic [NB_ADDR-1:0] addr);
    case (sel)
      4'd1:    return reg_mem[addr];
      4'd2:    return dmem[addr];
      4'd4:    return latch_mem[addr];
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Predicts the response word and the edge-to-ack latency of one command.
  function automatic logic [31:0] predict(input logic [3:0] op, input logic [24:0] arg,
                                          input bit running, output int lat);
    int n;
    lat = NB_SYNC + 3;
    case (op)
      4'd0: ;
      4'd1: begin m_halted = 0; lat = -1; end
      4'd2: begin
        n = (arg[15:0] == 16'd0) ? 1 : int'(arg[15:0]);
        m_cycles = m_cycles + 32'(n);
        m_halted = 0;
        lat = NB_SYNC + 3 + n;
      end
      4'd3: if (running) lat = -1;
      4'd4: begin m_last = reg_mem[{5'd0, arg[4:0]}]; lat = NB_SYNC + 4 + READ_LAT; m_reads++; end
      4'd5: begin m_last = dmem[arg[9:0]];            lat = NB_SYNC + 4 + READ_LAT; m_reads++; end
      4'd6: begin m_last = latch_mem[arg[9:0]];       lat = NB_SYNC + 4 + READ_LAT; m_reads++; end
      4'd7: m_last = {29'd0, m_halted, 2'b00};
      4'd8: m_last = m_cycles;
      default: m_last = 32'hFFFF_FFFF;
    endcase
    return m_last;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Lowers the strobe long enough to be seen low, then raises it with the
  // new command; optionally queues the expected response.
  task automatic applyStimulus(input logic [3:0] op, input logic [24:0] arg, input bit push,
                               input logic [31:0] exp_data, input int lat, input string name);
    exp_t e;
    @(negedge clk);
    gpio_cmd[30] = 1'b0;
    repeat (NB_SYNC + 1) @(negedge clk);
    gpio_cmd = {1'($urandom), 1'b1, 1'($urandom), op, arg};
    if (push) begin
      e.data    = exp_data;
      e.exp_cyc = (lat < 0) ? -1 : cyc + lat;
      e.name    = name;
      sb_q.push_back(e);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [24:0] arg, input bit running, input string name);
    logic [31:0] d;
    int lat;
    d = predict(op, arg, running, lat);
    applyStimulus(op, arg, 1'b1, d, lat, name);
  endtask

  task automatic waitAck(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout actual=no_ack expected=ack", name);
      sb_q.delete();
    end
  endtask

  // Debug source responder: data is valid only READ_LAT cycles after the
  // request cycle, using the select/address presented with the request.
  always @(negedge clk) begin
    if (rst) begin
      req_age  = -1;
      dbg_data = $urandom;
    end else begin
      if (dbg_req) begin
        req_sel  = dbg_sel;
        req_addr = dbg_addr;
        req_age  = 0;
        req_count++;
      end else if (req_age >= 0) begin
        req_age++;
      end
      if (req_age == READ_LAT) begin
        dbg_data = src_read(req_sel, req_addr);
        req_age  = -1;
      end else begin
        dbg_data = $urandom;
      end
    end
  end

  // Monitor: one scoreboard pop per ack toggle.
  always @(negedge clk) begin
    if (rst) begin
      prev_ack = 1'b0;
    end else begin
      if (pipe_en) pe_count++;
      if (ack !== prev_ack) begin
        prev_ack = ack;
        ack_count++;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_ack actual=toggle expected=none cyc=%0d", cyc);
        end else begin
          mon_e = sb_q.pop_front();
          checkOutput({mon_e.name, "_data"}, gpio_rsp, mon_e.data);
          if (mon_e.exp_cyc >= 0)
            checkOutput({mon_e.name, "_latency"}, 32'(cyc), 32'(mon_e.exp_cyc));
        end
      end
    end
  end

  initial begin
    int pe0;
    int ack0;
    logic [3:0]  op;
    logic [24:0] arg;

    rst = 1'b1;
    gpio_cmd = '0;
    halt = 1'b0;
    for (int k = 0; k < 1024; k++) begin
      reg_mem[k]   = $urandom;
      dmem[k]      = $urandom;
      latch_mem[k] = $urandom;
    end
    m_cycles = 0;
    m_last   = 0;
    m_halted = 0;
    m_reads  = 0;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_gpio", gpio_rsp, 32'd0);
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_pipe_en", 32'(pipe_en), 32'd0);
    checkOutput("rst_dbg_sel", 32'(dbg_sel), 32'd0);
    checkOutput("rst_dbg_addr", 32'(dbg_addr), 32'd0);
    checkOutput("rst_dbg_req", 32'(dbg_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single and multi-step.
    pe0 = pe_count;
    issue(4'd2, 25'd5, 0, "step5");
    waitAck("step5");
    checkOutput("step5_enabled_cycles", 32'(pe_count - pe0), 32'd5);
    pe0 = pe_count;
    issue(4'd2, 25'd0, 0, "step0");
    waitAck("step0");
    checkOutput("step0_enabled_cycles", 32'(pe_count - pe0), 32'd1);
    issue(4'd8, 25'd0, 0, "cycles_after_steps");
    waitAck("cycles_after_steps");

    // Run until the core halts after 20 enabled cycles.
    pe0 = pe_count;
    issue(4'd1, 25'd0, 0, "run_halt");
    waitAck("run_halt");
    checkOutput("run_busy_low", 32'(busy), 32'd0);
    repeat (19) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("halt_pipe_en_low", 32'(pipe_en), 32'd0);
    halt = 1'b0;
    checkOutput("run_enabled_cycles", 32'(pe_count - pe0), 32'd20);
    m_cycles = m_cycles + 32'd20;
    m_halted = 1;
    issue(4'd7, 25'd0, 0, "status_halted");
    waitAck("status_halted");
    issue(4'd8, 25'd0, 0, "cycles_after_run");
    waitAck("cycles_after_run");

    // Reads.
    issue(4'd5, 25'h3C3, 0, "rdmem_3c3");
    waitAck("rdmem_3c3");
    checkOutput("rdmem_req_sel", 32'(req_sel), 32'd2);
    checkOutput("rdmem_req_addr", 32'(req_addr), 32'h3C3);
    issue(4'd4, 25'h1F3A5, 0, "rdreg_masked");
    waitAck("rdreg_masked");
    checkOutput("rdreg_req_addr", 32'(req_addr), 32'h5);
    issue(4'd6, 25'h2B7, 0, "rdlatch");
    waitAck("rdlatch");
    issue(4'd12, 25'h123, 0, "illegal12");
    waitAck("illegal12");

    // A strobe edge during a long step must be ignored.
    ack0 = ack_count;
    issue(4'd2, 25'd100, 0, "step100");
    repeat (30) @(negedge clk);
    applyStimulus(4'd8, 25'd0, 1'b0, 32'd0, -1, "ignored");
    waitAck("step100");
    repeat (20) @(negedge clk);
    checkOutput("step100_ack_count", 32'(ack_count - ack0), 32'd1);

    // Randomized command mix.
    for (int i = 0; i < 30; i++) begin
      arg = 25'($urandom);
      case ($urandom_range(0, 8))
        0: op = 4'd0;
        1: begin op = 4'd2; arg = {arg[24:16], 16'($urandom_range(0, 12))}; end
        2: op = 4'd7;
        3: op = 4'd8;
        4: op = 4'd4;
        5: op = 4'd5;
        6: op = 4'd6;
        7: op = 4'(9 + $urandom_range(0, 6));
        default: op = 4'd8;
      endcase
      issue(op, arg, 0, $sformatf("rand%0d_op%0d", i, op));
      waitAck($sformatf("rand%0d", i));
    end

    // Cycle counter wrap.
    @(negedge clk);
    force dut.cycle_cnt = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.cycle_cnt;
    m_cycles = 32'hFFFF_FFFE;
    issue(4'd2, 25'd3, 0, "step3_wrap");
    waitAck("step3_wrap");
    issue(4'd8, 25'd0, 0, "cycles_wrapped");
    waitAck("cycles_wrapped");

    // STOP while running.
    issue(4'd1, 25'd0, 0, "run_for_stop");
    waitAck("run_for_stop");
    repeat (10) @(negedge clk);
    checkOutput("running_pipe_en", 32'(pipe_en), 32'd1);
    issue(4'd3, 25'd0, 1, "stop_in_run");
    waitAck("stop_in_run");
    @(negedge clk);
    #1;
    checkOutput("stop_pipe_en_low", 32'(pipe_en), 32'd0);

    // Reset in the middle of a run.
    issue(4'd1, 25'd0, 0, "run_for_reset");
    waitAck("run_for_reset");
    repeat (5) @(negedge clk);
    gpio_cmd = '0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrun_rst_pipe_en", 32'(pipe_en), 32'd0);
    checkOutput("midrun_rst_ack", 32'(ack), 32'd0);
    checkOutput("midrun_rst_busy", 32'(busy), 32'd0);
    sb_q.delete();
    m_cycles = 0;
    m_last   = 0;
    m_halted = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    issue(4'd8, 25'd0, 0, "cycles_after_reset");
    waitAck("cycles_after_reset");

    checkOutput("dbg_req_pulses", 32'(req_count), 32'(m_reads));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
